mem_bus_arbiter: RTL and testbench
==================================

# mem_bus_arbiter

Parametrised N-port arbiter between the processor's memory clients (icache, dcache MSHR, prefetch) and the single tagged memory bus (`mem` model / `proc2mem_*`). It picks one requesting port per cycle, forwards the bus acceptance tag to that port, and records which port owns each tag. When data returns, it routes the data to the owning port by tag. It replaces hard-wired two-client muxing inside `pipeline`.

## Interface
- `N_PORTS`, 2: number of client ports (≥2).
- `TAG_W`, 4: bus tag width; tag 0 means none/rejected, so `2**TAG_W-1` usable tags.
- `ADDR_W`, 32: address width (`XLEN`).
- `DATA_W`, 64: bus data width.
- `clock`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-high.
- `port_command`  in  N_PORTS×2  per-port BUS_NONE/BUS_LOAD/BUS_STORE.
- `port_addr`  in  N_PORTS×ADDR_W  per-port address.
- `port_data`  in  N_PORTS×DATA_W  per-port store data.
- `port_response`  out  N_PORTS×TAG_W  acceptance tag for the granted port; 0 elsewhere.
- `port_tag`  out  N_PORTS×TAG_W  returning tag, driven only on the owning port.
- `port_rdata`  out  N_PORTS×DATA_W  `mem2proc_data` broadcast to all ports.
- `proc2mem_command`  out  2  forwarded command.
- `proc2mem_addr`  out  ADDR_W  forwarded address.
- `proc2mem_data`  out  DATA_W  forwarded data.
- `mem2proc_response`  in  TAG_W  bus acceptance tag.
- `mem2proc_tag`  in  TAG_W  bus return tag.
- `mem2proc_data`  in  DATA_W  bus return data.
- `outstanding`  out  TAG_W+1  count of live owner entries.
- `orphan_err`  out  1  sticky; a return tag had no owner.

## Operation
- Requesters: ports with command ≠ BUS_NONE. Winner is chosen by a rotating priority starting at `rr_ptr`. The winner's command, address and data drive `proc2mem_*`. With no requester, the bus carries BUS_NONE.
- The grant is accepted when `mem2proc_response ≠ 0` in the same cycle. The winner's `port_response` equals `mem2proc_response`. All other ports see 0 and must hold their request.
- On an accepted BUS_LOAD, the owner table entry [response] is written at posedge with valid=1 and owner=winner. `outstanding` increments.
- On an accepted BUS_STORE, no entry is allocated.
- On an accepted grant, `rr_ptr` moves to winner+1 mod N_PORTS. On a rejected grant or an idle cycle, `rr_ptr` holds, so the rejected winner keeps priority.
- Return, when `mem2proc_tag ≠ 0`:
  - If the entry is valid, `port_tag[owner] = mem2proc_tag`. The entry clears at posedge and `outstanding` decrements.
  - If the entry is invalid, the return is dropped and `orphan_err` is set at posedge.
- Same cycle, return tag t and new acceptance of t: the clear happens first and the allocate wins. Entry t ends valid with the new owner, and `outstanding` is unchanged.
- A return in the same cycle as its own acceptance is not bypassed and is treated as an orphan.

## Timing
- Request to bus and acceptance to port: combinational, 0 cycles. Owner table and `rr_ptr` update at posedge.
- Return to `port_tag`/`port_rdata`: combinational from the registered table, 0 cycles.
- Reset, synchronous, applies to all registered state:
  - `rr_ptr`=0, all owner entries invalid, `outstanding`=0, `orphan_err`=0.
  - While `reset`=1, `proc2mem_command`=BUS_NONE and every `port_response`/`port_tag`=0.
- Reset mid-operation drops all ownership. Tags returning after reset are orphans and set `orphan_err`.
- Full table: the memory does not issue a live tag twice. If it does, the entry is overwritten, `orphan_err` is set, and `outstanding` is unchanged.

## Configuration
- `MEM_ARB_ROUND_ROBIN_EN` defined: rotating priority as above.
- Not defined: fixed priority with port 0 highest. `rr_ptr` is not built and everything else is identical.

## Structure
- Shared package `sys_defs`: the existing `BUS_COMMAND` enum, plus a new `MEM_ARB_OWNER_ENTRY` typedef with fields `valid` and `owner[$clog2(N_PORTS)]`.
- Sub-module `rr_picker`: N-request one-hot/index picker with a priority-start input. It is combinational and also used with start=0 for the fixed-priority build.

## Test plan
- Single load, port 1 (N_PORTS=2):
  - Addr 0x100, response 3 → `port_response[1]`=3, `outstanding`=1.
  - Later tag 3 with data 0xDEAD → `port_tag[1]`=3, `port_rdata`=0xDEAD, `outstanding`=0.
- Contention, both ports loading every cycle with memory always accepting (tags 1, 2, 3, 4) → grants alternate 0, 1, 0, 1. Without the macro, all grants go to port 0.
- Rejection, port 0 winner with response 0 for 2 cycles → `rr_ptr` holds and port 0 is granted on the 3rd cycle when response is 5.
- Store on port 0, response 7 → `outstanding` stays 0. A later tag 7 → `orphan_err`=1 and no `port_tag` is asserted.
- Reuse of tag 2: return of tag 2 (owner port 0) in the same cycle as new acceptance of tag 2 for port 1 → `port_tag[0]`=2 that cycle, then entry 2 is owned by port 1 and `outstanding` is unchanged.
- Reset mid-operation with 3 outstanding loads → `outstanding`=0. A subsequent tag return → orphan, `orphan_err`=1.

Source files
------------

// File: rtl/sys_defs.sv
// ============================================================================
// Module      : sys_defs (package)
// Description : Shared processor definitions: memory bus command encoding and
//               the owner-table entry used by mem_bus_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sys_defs;

    typedef enum logic [1:0] {
        BUS_NONE  = 2'h0,
        BUS_LOAD  = 2'h1,
        BUS_STORE = 2'h2
    } BUS_COMMAND;

    // Owner field is sized for up to 16 client ports; the arbiter stores its
    // $clog2(N_PORTS)-bit winner index zero-extended into it.
    localparam int c_MEM_ARB_OWNER_W = 4;

    typedef struct packed {
        logic                         valid;
        logic [c_MEM_ARB_OWNER_W-1:0] owner;
    } MEM_ARB_OWNER_ENTRY;

endpackage

`default_nettype wire

// File: rtl/rr_picker.sv
// ============================================================================
// Module      : rr_picker
// Description : Combinational N-request picker. Scans requests starting at
//               i_start and wrapping; returns one-hot grant and its index.
//               With i_start tied to 0 it is a fixed-priority picker.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_picker #(
    parameter int N_REQ = 2,
    parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IDX_W-1:0] i_start,
    output logic [N_REQ-1:0] o_grant,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_valid
);

    // First requester found walking upward from i_start (mod N_REQ) wins.
    always_comb begin
        int k;
        k       = 0;
        o_grant = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            k = int'(i_start) + i;
            if (k >= N_REQ) begin
                k = k - N_REQ;
            end
            if (!o_valid && i_req[k]) begin
                o_valid    = 1'b1;
                o_grant[k] = 1'b1;
                o_idx      = IDX_W'(k);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
// ============================================================================
// Module      : mem_bus_arbiter
// Description : N-port arbiter onto the single tagged memory bus. Grants one
//               requester per cycle, forwards the acceptance tag, records the
//               owner of each load tag and routes returning tags by owner.
//               Build option MEM_ARB_ROUND_ROBIN_EN selects rotating priority;
//               without it port 0 has fixed highest priority.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_bus_arbiter
    import sys_defs::*;
#(
    parameter int N_PORTS = 2,
    parameter int TAG_W   = 4,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 64
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [N_PORTS*2-1:0]      port_command,
    input  logic [N_PORTS*ADDR_W-1:0] port_addr,
    input  logic [N_PORTS*DATA_W-1:0] port_data,
    output logic [N_PORTS*TAG_W-1:0]  port_response,
    output logic [N_PORTS*TAG_W-1:0]  port_tag,
    output logic [N_PORTS*DATA_W-1:0] port_rdata,
    output logic [1:0]                proc2mem_command,
    output logic [ADDR_W-1:0]         proc2mem_addr,
    output logic [DATA_W-1:0]         proc2mem_data,
    input  logic [TAG_W-1:0]          mem2proc_response,
    input  logic [TAG_W-1:0]          mem2proc_tag,
    input  logic [DATA_W-1:0]         mem2proc_data,
    output logic [TAG_W:0]            outstanding,
    output logic                      orphan_err
);

    localparam int c_IDX_W  = $clog2(N_PORTS);
    localparam int c_N_TAGS = 2 ** TAG_W;

    logic [N_PORTS-1:0] w_req;
    logic [N_PORTS-1:0] w_grant;
    logic [c_IDX_W-1:0] w_start;
    logic [c_IDX_W-1:0] w_win_idx;
    logic               w_any;
    logic               w_grant_valid;
    logic [1:0]         w_win_cmd;
    logic               w_accept;
    logic               w_accept_load;
    logic               w_ret;
    logic               w_ret_hit;
    logic               w_ret_orphan;
    logic               w_live_overwrite;
    logic               w_inc;
    logic               w_dec;
    MEM_ARB_OWNER_ENTRY w_ret_entry;
    MEM_ARB_OWNER_ENTRY w_alloc_entry;

    MEM_ARB_OWNER_ENTRY r_table [c_N_TAGS];
    logic [TAG_W:0]     r_outstanding;
    logic               r_orphan_err;

    generate
        for (genvar gi = 0; gi < N_PORTS; gi++) begin : g_port
            assign w_req[gi] = (port_command[gi*2 +: 2] != BUS_NONE);
            // Only the granted port sees the acceptance tag.
            assign port_response[gi*TAG_W +: TAG_W] =
                (w_grant_valid && w_grant[gi]) ? mem2proc_response : '0;
            assign port_rdata[gi*DATA_W +: DATA_W] = mem2proc_data;
        end
    endgenerate

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic [c_IDX_W-1:0] r_rr_ptr;

    // Priority moves past the winner only when the bus accepts it.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_rr_ptr <= '0;
        end else if (w_accept) begin
            r_rr_ptr <= (w_win_idx == c_IDX_W'(N_PORTS - 1)) ? '0 : w_win_idx + 1'b1;
        end
    end

    assign w_start = r_rr_ptr;
`else
    assign w_start = '0;
`endif

    rr_picker #(
        .N_REQ (N_PORTS),
        .IDX_W (c_IDX_W)
    ) u_picker (
        .i_req   (w_req),
        .i_start (w_start),
        .o_grant (w_grant),
        .o_idx   (w_win_idx),
        .o_valid (w_any)
    );

    assign w_grant_valid    = w_any && !reset;
    assign w_win_cmd        = port_command[int'(w_win_idx)*2 +: 2];
    assign proc2mem_command = w_grant_valid ? w_win_cmd : BUS_NONE;
    assign proc2mem_addr    = w_grant_valid ? port_addr[int'(w_win_idx)*ADDR_W +: ADDR_W] : '0;
    assign proc2mem_data    = w_grant_valid ? port_data[int'(w_win_idx)*DATA_W +: DATA_W] : '0;

    assign w_accept      = w_grant_valid && (mem2proc_response != '0);
    assign w_accept_load = w_accept && (w_win_cmd == BUS_LOAD);

    assign w_ret         = !reset && (mem2proc_tag != '0);
    assign w_ret_entry   = r_table[mem2proc_tag];
    assign w_ret_hit     = w_ret && w_ret_entry.valid;
    assign w_ret_orphan  = w_ret && !w_ret_entry.valid;
    assign w_alloc_entry = r_table[mem2proc_response];

    // Allocating over a live entry is a protocol error, unless that same
    // entry is being retired by a return in this cycle (legal tag reuse).
    assign w_live_overwrite = w_accept_load && w_alloc_entry.valid &&
                              !(w_ret_hit && (mem2proc_tag == mem2proc_response));
    assign w_inc = w_accept_load && !w_live_overwrite;
    assign w_dec = w_ret_hit;

    // Route a returning tag only to the port that owns it.
    always_comb begin
        port_tag = '0;
        if (w_ret_hit) begin
            port_tag[int'(w_ret_entry.owner)*TAG_W +: TAG_W] = mem2proc_tag;
        end
    end

    // Owner table: retire on return first, then allocate so reuse wins.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int t = 0; t < c_N_TAGS; t++) begin
                r_table[t] <= '0;
            end
        end else begin
            if (w_ret_hit) begin
                r_table[mem2proc_tag].valid <= 1'b0;
            end
            if (w_accept_load) begin
                r_table[mem2proc_response].valid <= 1'b1;
                r_table[mem2proc_response].owner <= c_MEM_ARB_OWNER_W'(w_win_idx);
            end
        end
    end

    // Live-entry count and sticky orphan/overwrite error flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_outstanding <= '0;
            r_orphan_err  <= 1'b0;
        end else begin
            if (w_inc && !w_dec) begin
                r_outstanding <= r_outstanding + 1'b1;
            end else if (w_dec && !w_inc) begin
                r_outstanding <= r_outstanding - 1'b1;
            end
            if (w_ret_orphan || w_live_overwrite) begin
                r_orphan_err <= 1'b1;
            end
        end
    end

    assign outstanding = r_outstanding;
    assign orphan_err  = r_orphan_err;

endmodule

`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
// ============================================================================
// Module      : tb_mem_bus_arbiter
// Description : Self-checking bench for mem_bus_arbiter (N_PORTS=2). Accepted
//               loads are pushed to a scoreboard; returns pop the owner entry
//               to form the expected port_tag. Outstanding is the scoreboard
//               depth.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_bus_arbiter;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic [3:0]   port_command = '0;
    logic [63:0]  port_addr = '0;
    logic [127:0] port_data = '0;
    logic [7:0]   port_response;
    logic [7:0]   port_tag;
    logic [127:0] port_rdata;
    logic [1:0]   proc2mem_command;
    logic [31:0]  proc2mem_addr;
    logic [63:0]  proc2mem_data;
    logic [3:0]   mem2proc_response = '0;
    logic [3:0]   mem2proc_tag = '0;
    logic [63:0]  mem2proc_data = '0;
    logic [4:0]   outstanding;
    logic         orphan_err;

    mem_bus_arbiter #(
        .N_PORTS (2),
        .TAG_W   (4),
        .ADDR_W  (32),
        .DATA_W  (64)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .port_command      (port_command),
        .port_addr         (port_addr),
        .port_data         (port_data),
        .port_response     (port_response),
        .port_tag          (port_tag),
        .port_rdata        (port_rdata),
        .proc2mem_command  (proc2mem_command),
        .proc2mem_addr     (proc2mem_addr),
        .proc2mem_data     (proc2mem_data),
        .mem2proc_response (mem2proc_response),
        .mem2proc_tag      (mem2proc_tag),
        .mem2proc_data     (mem2proc_data),
        .outstanding       (outstanding),
        .orphan_err        (orphan_err)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [3:0] tag;
        int         port;
    } sb_t;

    sb_t sb[$];
    int  n_checks = 0;
    int  n_fail   = 0;
    int  rr_m     = 0;

    localparam logic [1:0] NONE  = 2'h0;
    localparam logic [1:0] LOAD  = 2'h1;
    localparam logic [1:0] STORE = 2'h2;

    // Reference winner for the active build.
    function automatic int exp_winner(input bit r0, input bit r1);
        if (r0 && r1) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            return rr_m;
`else
            return 0;
`endif
        end
        if (r0) return 0;
        if (r1) return 1;
        return -1;
    endfunction

    function automatic logic [7:0] resp_vec(input logic [3:0] tag, input int port);
        logic [7:0] v;
        v = {4'h0, tag};
        return v << (4 * port);
    endfunction

    // Expected port_tag for a return: owner from the scoreboard, entry retired.
    function automatic logic [7:0] sb_pop(input logic [3:0] tag);
        logic [7:0] e;
        e = '0;
        for (int i = 0; i < sb.size(); i++) begin
            if (sb[i].tag == tag) begin
                e = resp_vec(tag, sb[i].port);
                sb.delete(i);
                break;
            end
        end
        return e;
    endfunction

    task automatic drive_ports(input logic [1:0] c0, input logic [31:0] a0, input logic [63:0] d0,
                               input logic [1:0] c1, input logic [31:0] a1, input logic [63:0] d1);
        port_command = {c1, c0};
        port_addr    = {a1, a0};
        port_data    = {d1, d0};
    endtask

    task automatic drive_mem(input logic [3:0] resp, input logic [3:0] tag, input logic [63:0] data);
        mem2proc_response = resp;
        mem2proc_tag      = tag;
        mem2proc_data     = data;
    endtask

    task automatic test_reset;
        @(negedge clock);
        drive_ports(LOAD, 32'h40, 64'h0, LOAD, 32'h80, 64'h0);
        drive_mem(4'd3, 4'd3, 64'h0);
        #1;
        n_checks++;
        if (proc2mem_command !== NONE) begin
            n_fail++; $display("FAIL reset_cmd: got %0h expected %0h", proc2mem_command, NONE);
        end
        n_checks++;
        if (port_response !== 8'h00) begin
            n_fail++; $display("FAIL reset_resp: got %0h expected 0", port_response);
        end
        n_checks++;
        if (port_tag !== 8'h00) begin
            n_fail++; $display("FAIL reset_tag: got %0h expected 0", port_tag);
        end
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        drive_ports(NONE, 0, 0, NONE, 0, 0);
        drive_mem(0, 0, 0);
        #1;
        n_checks++;
        if (outstanding !== 5'd0 || orphan_err !== 1'b0) begin
            n_fail++; $display("FAIL reset_state: got out=%0d err=%0b expected 0/0", outstanding, orphan_err);
        end
    endtask

    task automatic test_single_load;
        logic [7:0] e;
        @(negedge clock);
        drive_ports(NONE, 0, 0, LOAD, 32'h100, 64'h0);
        drive_mem(4'd3, 0, 0);
        #1;
        n_checks++;
        if (proc2mem_command !== LOAD || proc2mem_addr !== 32'h100) begin
            n_fail++; $display("FAIL single_bus: got cmd=%0h addr=%0h expected 1/100", proc2mem_command, proc2mem_addr);
        end
        n_checks++;
        if (port_response !== resp_vec(4'd3, 1)) begin
            n_fail++; $display("FAIL single_resp: got %0h expected %0h", port_response, resp_vec(4'd3, 1));
        end
        sb.push_back('{tag: 4'd3, port: 1});
        rr_m = 0;
        @(posedge clock); #1;
        n_checks++;
        if (outstanding !== 5'(sb.size())) begin
            n_fail++; $display("FAIL single_out: got %0d expected %0d", outstanding, sb.size());
        end
        @(negedge clock);
        drive_ports(NONE, 0, 0, NONE, 0, 0);
        drive_mem(0, 4'd3, 64'hDEAD);
        e = sb_pop(4'd3);
        #1;
        n_checks++;
        if (port_tag !== e || port_rdata !== {64'hDEAD, 64'hDEAD}) begin
            n_fail++; $display("FAIL single_ret: got tag=%0h rdata=%0h expected tag=%0h rdata=dead", port_tag, port_rdata, e);
        end
        @(posedge clock); #1;
        n_checks++;
        if (outstanding !== 5'(sb.size())) begin
            n_fail++; $display("FAIL single_out_done: got %0d expected %0d", outstanding, sb.size());
        end
    endtask

    task automatic test_contention;
        int w;
        logic [7:0] e;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clock);
            drive_ports(LOAD, 32'h1000 + 32'(c), 64'h0, LOAD, 32'h2000 + 32'(c), 64'h0);
            drive_mem(4'(c), 0, 0);
            w = exp_winner(1'b1, 1'b1);
            #1;
            n_checks++;
            if (port_response !== resp_vec(4'(c), w)) begin
                n_fail++; $display("FAIL contention_resp%0d: got %0h expected %0h", c, port_response, resp_vec(4'(c), w));
            end
            n_checks++;
            if (proc2mem_addr !== ((w == 0) ? 32'h1000 : 32'h2000) + 32'(c)) begin
                n_fail++; $display("FAIL contention_addr%0d: got %0h expected winner %0d", c, proc2mem_addr, w);
            end
            sb.push_back('{tag: 4'(c), port: w});
            rr_m = (w + 1) % 2;
            @(posedge clock);
        end
        #1;
        n_checks++;
        if (outstanding !== 5'(sb.size())) begin
            n_fail++; $display("FAIL contention_out: got %0d expected %0d", outstanding, sb.size());
        end
        for (int c = 1; c <= 4; c++) begin
            @(negedge clock);
            drive_ports(NONE, 0, 0, NONE, 0, 0);
            drive_mem(0, 4'(c), 64'(c) * 64'h11);
            e = sb_pop(4'(c));
            #1;
            n_checks++;
            if (port_tag !== e) begin
                n_fail++; $display("FAIL contention_ret%0d: got %0h expected %0h", c, port_tag, e);
            end
            @(posedge clock);
        end
        #1;
        n_checks++;
        if (outstanding !== 5'd0) begin
            n_fail++; $display("FAIL contention_drain: got %0d expected 0", outstanding);
        end
    endtask

    task automatic test_rejection;
        int w;
        logic [7:0] e;
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            drive_ports(LOAD, 32'h300, 64'h0, LOAD, 32'h400, 64'h0);
            drive_mem((c == 2) ? 4'd5 : 4'd0, 0, 0);
            w = exp_winner(1'b1, 1'b1);
            #1;
            n_checks++;
            if (w != 0 || proc2mem_addr !== 32'h300) begin
                n_fail++; $display("FAIL reject_winner%0d: got addr=%0h expected 300 (model winner %0d)", c, proc2mem_addr, w);
            end
            n_checks++;
            if (port_response !== ((c == 2) ? resp_vec(4'd5, 0) : 8'h00)) begin
                n_fail++; $display("FAIL reject_resp%0d: got %0h", c, port_response);
            end
            if (c == 2) begin
                sb.push_back('{tag: 4'd5, port: 0});
                rr_m = 1;
            end
            @(posedge clock);
        end
        @(negedge clock);
        drive_ports(NONE, 0, 0, LOAD, 32'h400, 64'h0);
        drive_mem(4'd6, 0, 0);
        #1;
        n_checks++;
        if (port_response !== resp_vec(4'd6, 1)) begin
            n_fail++; $display("FAIL reject_port1: got %0h expected %0h", port_response, resp_vec(4'd6, 1));
        end
        sb.push_back('{tag: 4'd6, port: 1});
        rr_m = 0;
        @(posedge clock);
        for (int c = 5; c <= 6; c++) begin
            @(negedge clock);
            drive_ports(NONE, 0, 0, NONE, 0, 0);
            drive_mem(0, 4'(c), 64'h0);
            e = sb_pop(4'(c));
            #1;
            n_checks++;
            if (port_tag !== e) begin
                n_fail++; $display("FAIL reject_ret%0d: got %0h expected %0h", c, port_tag, e);
            end
            @(posedge clock);
        end
    endtask

    task automatic test_reuse;
        logic [7:0] e;
        @(negedge clock);
        drive_ports(LOAD, 32'h500, 64'h0, NONE, 0, 0);
        drive_mem(4'd2, 0, 0);
        sb.push_back('{tag: 4'd2, port: 0});
        @(posedge clock);
        @(negedge clock);
        drive_ports(NONE, 0, 0, LOAD, 32'h600, 64'h0);
        drive_mem(4'd2, 4'd2, 64'hBEEF);
        e = sb_pop(4'd2);
        sb.push_back('{tag: 4'd2, port: 1});
        #1;
        n_checks++;
        if (port_tag !== e || port_response !== resp_vec(4'd2, 1)) begin
            n_fail++; $display("FAIL reuse_same_cycle: got tag=%0h resp=%0h expected tag=%0h resp=%0h", port_tag, port_response, e, resp_vec(4'd2, 1));
        end
        @(posedge clock); #1;
        n_checks++;
        if (outstanding !== 5'(sb.size()) || orphan_err !== 1'b0) begin
            n_fail++; $display("FAIL reuse_state: got out=%0d err=%0b expected %0d/0", outstanding, orphan_err, sb.size());
        end
        @(negedge clock);
        drive_ports(NONE, 0, 0, NONE, 0, 0);
        drive_mem(0, 4'd2, 64'h0);
        e = sb_pop(4'd2);
        #1;
        n_checks++;
        if (port_tag !== e) begin
            n_fail++; $display("FAIL reuse_new_owner: got %0h expected %0h", port_tag, e);
        end
        @(posedge clock);
    endtask

    task automatic test_store;
        @(negedge clock);
        drive_ports(STORE, 32'h700, 64'h1234_5678_9ABC_DEF0, NONE, 0, 0);
        drive_mem(4'd7, 0, 0);
        #1;
        n_checks++;
        if (proc2mem_command !== STORE || proc2mem_data !== 64'h1234_5678_9ABC_DEF0 || port_response !== resp_vec(4'd7, 0)) begin
            n_fail++; $display("FAIL store_bus: got cmd=%0h data=%0h resp=%0h", proc2mem_command, proc2mem_data, port_response);
        end
        @(posedge clock); #1;
        n_checks++;
        if (outstanding !== 5'd0) begin
            n_fail++; $display("FAIL store_out: got %0d expected 0", outstanding);
        end
        @(negedge clock);
        drive_ports(NONE, 0, 0, NONE, 0, 0);
        drive_mem(0, 4'd7, 64'h0);
        #1;
        n_checks++;
        if (port_tag !== 8'h00) begin
            n_fail++; $display("FAIL store_ret_tag: got %0h expected 0", port_tag);
        end
        @(posedge clock); #1;
        n_checks++;
        if (orphan_err !== 1'b1) begin
            n_fail++; $display("FAIL store_orphan: got %0b expected 1", orphan_err);
        end
    endtask

    task automatic test_reset_mid;
        for (int c = 8; c <= 10; c++) begin
            @(negedge clock);
            drive_ports(LOAD, 32'h800 + 32'(c), 64'h0, NONE, 0, 0);
            drive_mem(4'(c), 0, 0);
            sb.push_back('{tag: 4'(c), port: 0});
            @(posedge clock);
        end
        #1;
        n_checks++;
        if (outstanding !== 5'(sb.size())) begin
            n_fail++; $display("FAIL mid_out_before: got %0d expected %0d", outstanding, sb.size());
        end
        @(negedge clock);
        reset = 1'b1;
        drive_mem(4'd11, 4'd8, 64'h0);
        #1;
        n_checks++;
        if (proc2mem_command !== NONE || port_response !== 8'h00 || port_tag !== 8'h00) begin
            n_fail++; $display("FAIL mid_reset_outputs: got cmd=%0h resp=%0h tag=%0h expected 0", proc2mem_command, port_response, port_tag);
        end
        @(posedge clock);
        sb.delete();
        rr_m = 0;
        @(negedge clock);
        reset = 1'b0;
        drive_ports(NONE, 0, 0, NONE, 0, 0);
        drive_mem(0, 0, 0);
        #1;
        n_checks++;
        if (outstanding !== 5'd0 || orphan_err !== 1'b0) begin
            n_fail++; $display("FAIL mid_after_reset: got out=%0d err=%0b expected 0/0", outstanding, orphan_err);
        end
        @(negedge clock);
        drive_mem(0, 4'd9, 64'h0);
        #1;
        n_checks++;
        if (port_tag !== 8'h00) begin
            n_fail++; $display("FAIL mid_orphan_tag: got %0h expected 0", port_tag);
        end
        @(posedge clock); #1;
        n_checks++;
        if (orphan_err !== 1'b1) begin
            n_fail++; $display("FAIL mid_orphan_err: got %0b expected 1", orphan_err);
        end
    endtask

    initial begin
        test_reset();
        test_single_load();
        test_contention();
        test_rejection();
        test_reuse();
        test_store();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
